// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the arbitrated 2-bit alu: widths, opcodes, FSM states
// and the alu datapath itself.
package alu_arbiter_pkg;

    localparam int ALU_IN_W  = 2;
    localparam int ALU_OUT_W = 4;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;
    localparam logic [1:0] ALU_OP_MUL = 2'b10;
    localparam logic [1:0] ALU_OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    // Operands are zero-extended before the op, so add and multiply never truncate.
    function automatic logic [ALU_OUT_W-1:0] alu_eval(
        input logic [ALU_IN_W-1:0] a,
        input logic [ALU_IN_W-1:0] b,
        input logic [1:0]          sel
    );
        logic [ALU_OUT_W-1:0] ax;
        logic [ALU_OUT_W-1:0] bx;
        ax = {{(ALU_OUT_W-ALU_IN_W){1'b0}}, a};
        bx = {{(ALU_OUT_W-ALU_IN_W){1'b0}}, b};
        case (sel)
            ALU_OP_ADD: alu_eval = ax + bx;
            ALU_OP_SUB: alu_eval = ax - bx;
            ALU_OP_MUL: alu_eval = ax * bx;
            ALU_OP_XOR: alu_eval = ax ^ bx;
            default:    alu_eval = '0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found searching upward from last+1, wrapping modulo NREQ.
module alu_arbiter_rr #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant
);

    logic [IDW:0]      shift;
    logic [2*NREQ-1:0] req_dbl;
    logic [2*NREQ-1:0] rot_full;
    logic [2*NREQ-1:0] grant_dbl;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   rot_pick;

    // Rotate so last+1 sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        shift     = {1'b0, last} + (IDW+1)'(1);
        req_dbl   = {req, req};
        rot_full  = req_dbl >> shift;
        rot       = rot_full[NREQ-1:0];
        rot_pick  = rot & (~rot + NREQ'(1));
        grant_dbl = {rot_pick, rot_pick} << shift;
        grant     = grant_dbl[2*NREQ-1:NREQ];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered 2-bit alu among NREQ valid/ready requesters with
// round-robin grants and a single operation in flight.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter  int NREQ  = 2,
    parameter  int CNT_W = 8,
    localparam int IDW   = (NREQ > 2) ? 2 : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [2*NREQ-1:0]     req_a,
    input  logic [2*NREQ-1:0]     req_b,
    input  logic [2*NREQ-1:0]     req_sel,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [ALU_OUT_W-1:0]  rsp_y,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);

    state_t                state;
    logic [ALU_IN_W-1:0]   op_a;
    logic [ALU_IN_W-1:0]   op_b;
    logic [1:0]            op_sel;
    logic [IDW-1:0]        owner;
    logic [IDW-1:0]        last;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       owner_oh;
    logic [IDW-1:0]        grant_id;
    logic [ALU_IN_W-1:0]   grant_a;
    logic [ALU_IN_W-1:0]   grant_b;
    logic [1:0]            grant_sel;
    logic [ALU_OUT_W-1:0]  alu_y;

    alu_arbiter_rr #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req   (req_valid),
        .last  (last),
        .grant (grant)
    );

    always_comb begin
        grant_id  = '0;
        grant_a   = '0;
        grant_b   = '0;
        grant_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_id  = IDW'(i);
                grant_a   = req_a[2*i +: 2];
                grant_b   = req_b[2*i +: 2];
                grant_sel = req_sel[2*i +: 2];
            end
        end
    end

    // The alu only ever sees the latched operands, so requester inputs may move freely once accepted.
    assign alu_y     = alu_eval(op_a, op_b, op_sel);
    assign owner_oh  = NREQ'(1) << owner;
    assign busy      = (state != S_IDLE);
    assign req_ready = (rst_n && state == S_IDLE) ? grant : '0;
    assign rsp_valid = (state == S_RESP) ? owner_oh : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_a     <= '0;
            op_b     <= '0;
            op_sel   <= '0;
            owner    <= '0;
            last     <= IDW'(NREQ-1);
            rsp_y    <= '0;
            rsp_id   <= '0;
            op_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        op_a   <= grant_a;
                        op_b   <= grant_b;
                        op_sel <= grant_sel;
                        owner  <= grant_id;
                        last   <= grant_id;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_y  <= alu_y;
                    rsp_id <= owner;
                    state  <= S_RESP;
                end
                S_RESP: begin
                    // Only the owner's rsp_ready retires the op; other requesters are ignored.
                    if (|(rsp_ready & owner_oh)) begin
                        op_count <= op_count + CNT_W'(1);
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
